// File: rtl/cpm_ingress_fifo.sv
// cpm_ingress_fifo: first-word fall-through elastic buffer feeding the CPM core input stream,
// with flush that never disturbs a stalled head, plus occupancy and traffic statistics.
module cpm_ingress_fifo #(
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6,
  parameter int CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_id,
  input  logic [3:0]                 in_opcode,
  input  logic [15:0]                in_payload,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_id,
  output logic [3:0]                 out_opcode,
  output logic [15:0]                out_payload,
  input  logic                       flush,
  input  logic                       clr_stats,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     high_water,
  output logic [CNT_W-1:0]           in_pkt_cnt,
  output logic [CNT_W-1:0]           out_pkt_cnt,
  output logic [CNT_W-1:0]           flush_drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [23:0]    r_mem [DEPTH];
  logic [AW-1:0]  r_wr, r_rd, w_wr_nx, w_rd_nx;
  logic [LW-1:0]  r_level, r_hw, w_lvl_nx, w_drop;
  logic [CNT_W-1:0] r_in_cnt, r_out_cnt, r_drop_cnt;
  logic [CNT_W:0] w_drop_sum;
  logic           r_af, w_push, w_pop;
  assign in_ready  = (r_level != LW'(DEPTH)) && !flush && !rst;
  assign out_valid = r_level != '0;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign {out_id, out_opcode, out_payload} = r_mem[r_rd];
  assign w_rd_nx   = r_rd + AW'(w_pop);
  // On flush only a head that is still stalled survives; writes rebase just behind it.
  assign w_lvl_nx  = flush ? LW'(out_valid && !out_ready) : r_level + LW'(w_push) - LW'(w_pop);
  assign w_wr_nx   = flush ? w_rd_nx + AW'(w_lvl_nx) : r_wr + AW'(w_push);
  assign w_drop    = (flush && out_valid) ? r_level - LW'(1) : '0;
  assign w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_drop);
  assign level          = r_level;
  assign almost_full    = r_af;
  assign high_water     = r_hw;
  assign in_pkt_cnt     = r_in_cnt;
  assign out_pkt_cnt    = r_out_cnt;
  assign flush_drop_cnt = r_drop_cnt;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= {in_id, in_opcode, in_payload};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_level    <= '0;
      r_af       <= 1'b0;
      r_hw       <= '0;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_wr    <= w_wr_nx;
      r_rd    <= w_rd_nx;
      r_level <= w_lvl_nx;
      r_af    <= w_lvl_nx >= LW'(AFULL_THRESH);
      if (clr_stats) begin
        r_hw       <= w_lvl_nx;
        r_in_cnt   <= '0;
        r_out_cnt  <= '0;
        r_drop_cnt <= '0;
      end else begin
        if (w_lvl_nx > r_hw) r_hw <= w_lvl_nx;
        r_in_cnt   <= r_in_cnt + CNT_W'(w_push);
        r_out_cnt  <= r_out_cnt + CNT_W'(w_pop);
        r_drop_cnt <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
      end
    end
endmodule

// File: tb/tb_cpm_ingress_fifo.sv
// tb_cpm_ingress_fifo: directed scenarios with hand-computed expectations; inputs change
// and outputs are sampled on the falling edge.
module tb_cpm_ingress_fifo;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, flush = 0, clr_stats = 0;
  logic [3:0] in_id = 0, in_opcode = 0, out_id, out_opcode;
  logic [15:0] in_payload = 0, out_payload;
  logic [3:0] level, high_water;
  logic almost_full;
  logic [15:0] in_pkt_cnt, out_pkt_cnt, flush_drop_cnt;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  cpm_ingress_fifo dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
    .in_opcode(in_opcode), .in_payload(in_payload), .out_valid(out_valid),
    .out_ready(out_ready), .out_id(out_id), .out_opcode(out_opcode),
    .out_payload(out_payload), .flush(flush), .clr_stats(clr_stats), .level(level),
    .almost_full(almost_full), .high_water(high_water), .in_pkt_cnt(in_pkt_cnt),
    .out_pkt_cnt(out_pkt_cnt), .flush_drop_cnt(flush_drop_cnt)
  );
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic clear_stats;
    clr_stats = 1;
    step();
    clr_stats = 0;
  endtask
  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, almost_full, level, high_water} !== 11'd0) begin
      failures++;
      $display("FAIL reset_flags got v=%b r=%b af=%b lvl=%0d hw=%0d exp all 0", out_valid, in_ready, almost_full, level, high_water);
    end
    checks++;
    if ({in_pkt_cnt, out_pkt_cnt, flush_drop_cnt} !== 48'd0) begin
      failures++;
      $display("FAIL reset_cnts got %0d/%0d/%0d exp 0/0/0", in_pkt_cnt, out_pkt_cnt, flush_drop_cnt);
    end
    rst = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got %b exp 1", in_ready); end
  endtask
  task automatic test_single;
    in_valid = 1; in_id = 4'd3; in_opcode = 4'd5; in_payload = 16'hBEEF; out_ready = 1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL single_no_bypass got %b exp 0", out_valid); end
    step();
    in_valid = 0;
    checks++;
    if ({out_valid, out_id, out_opcode, out_payload, level} !== {1'b1, 4'd3, 4'd5, 16'hBEEF, 4'd1}) begin
      failures++;
      $display("FAIL single_out got v=%b id=%0d op=%0d pl=%h lvl=%0d exp 1/3/5/beef/1", out_valid, out_id, out_opcode, out_payload, level);
    end
    step();
    checks++;
    if ({out_valid, level, in_pkt_cnt, out_pkt_cnt, high_water} !== {1'b0, 4'd0, 16'd1, 16'd1, 4'd1}) begin
      failures++;
      $display("FAIL single_after got v=%b lvl=%0d in=%0d out=%0d hw=%0d exp 0/0/1/1/1", out_valid, level, in_pkt_cnt, out_pkt_cnt, high_water);
    end
  endtask
  task automatic test_fill;
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_id = 4'(i); in_payload = 16'(i);
      step();
      checks++;
      if ({level, almost_full} !== {4'(i + 1), i + 1 >= 6}) begin
        failures++;
        $display("FAIL fill_level i=%0d got lvl=%0d af=%b exp %0d/%b", i, level, almost_full, i + 1, i + 1 >= 6);
      end
    end
    in_payload = 16'h0099;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if ({in_ready, out_valid, out_payload, level} !== {1'b0, 1'b1, 16'h0000, 4'd8}) begin
        failures++;
        $display("FAIL fill_hold c=%0d got rdy=%b v=%b pl=%h lvl=%0d exp 0/1/0000/8", c, in_ready, out_valid, out_payload, level);
      end
    end
    checks++;
    if ({high_water, in_pkt_cnt} !== {4'd8, 16'd9}) begin
      failures++;
      $display("FAIL fill_stats got hw=%0d in=%0d exp 8/9", high_water, in_pkt_cnt);
    end
  endtask
  task automatic test_full_pop;
    in_valid = 1; in_payload = 16'h0008; out_ready = 1;
    step();
    out_ready = 0;
    checks++;
    if ({level, in_ready, out_payload} !== {4'd7, 1'b1, 16'h0001}) begin
      failures++;
      $display("FAIL fullpop_no_push got lvl=%0d rdy=%b pl=%h exp 7/1/0001", level, in_ready, out_payload);
    end
    step();
    in_valid = 0; out_ready = 1;
    checks++;
    if (level !== 4'd8) begin failures++; $display("FAIL fullpop_push got lvl=%0d exp 8", level); end
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if ({out_valid, out_payload} !== {1'b1, 16'(k)}) begin
        failures++;
        $display("FAIL fullpop_order k=%0d got v=%b pl=%h exp 1/%h", k, out_valid, out_payload, 16'(k));
      end
      step();
    end
    checks++;
    if ({out_valid, level} !== {1'b0, 4'd0}) begin
      failures++;
      $display("FAIL fullpop_empty got v=%b lvl=%0d exp 0/0", out_valid, level);
    end
  endtask
  task automatic test_stream;
    clear_stats();
    checks++;
    if ({in_pkt_cnt, out_pkt_cnt, high_water} !== {16'd0, 16'd0, 4'd0}) begin
      failures++;
      $display("FAIL stream_clr got in=%0d out=%0d hw=%0d exp 0/0/0", in_pkt_cnt, out_pkt_cnt, high_water);
    end
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 100; i++) begin
      in_payload = 16'(i + 16'h100);
      step();
      checks++;
      if ({level, out_valid, out_payload} !== {4'd1, 1'b1, 16'(i + 16'h100)}) begin
        failures++;
        $display("FAIL stream i=%0d got lvl=%0d v=%b pl=%h exp 1/1/%h", i, level, out_valid, out_payload, 16'(i + 16'h100));
      end
    end
    in_valid = 0;
    step();
    checks++;
    if ({level, in_pkt_cnt, out_pkt_cnt, high_water} !== {4'd0, 16'd100, 16'd100, 4'd1}) begin
      failures++;
      $display("FAIL stream_end got lvl=%0d in=%0d out=%0d hw=%0d exp 0/100/100/1", level, in_pkt_cnt, out_pkt_cnt, high_water);
    end
  endtask
  task automatic test_flush;
    clear_stats();
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_payload = 16'(16'h10 + i);
      step();
    end
    flush = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got %b exp 0", in_ready); end
    step();
    flush = 0; in_valid = 0;
    checks++;
    if ({level, out_payload, flush_drop_cnt, in_pkt_cnt} !== {4'd1, 16'h0010, 16'd4, 16'd5}) begin
      failures++;
      $display("FAIL flush_stalled got lvl=%0d pl=%h drop=%0d in=%0d exp 1/0010/4/5", level, out_payload, flush_drop_cnt, in_pkt_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_payload = 16'(16'h20 + i);
      step();
    end
    in_valid = 0;
    checks++;
    if ({level, out_payload} !== {4'd5, 16'h0010}) begin
      failures++;
      $display("FAIL flush_refill got lvl=%0d pl=%h exp 5/0010", level, out_payload);
    end
    flush = 1; out_ready = 1;
    step();
    flush = 0; out_ready = 0;
    checks++;
    if ({level, out_valid, flush_drop_cnt, out_pkt_cnt} !== {4'd0, 1'b0, 16'd8, 16'd1}) begin
      failures++;
      $display("FAIL flush_pop got lvl=%0d v=%b drop=%0d out=%0d exp 0/0/8/1", level, out_valid, flush_drop_cnt, out_pkt_cnt);
    end
    in_valid = 1; in_payload = 16'h0055;
    step();
    in_valid = 0;
    checks++;
    if ({level, out_payload} !== {4'd1, 16'h0055}) begin
      failures++;
      $display("FAIL flush_rebase got lvl=%0d pl=%h exp 1/0055", level, out_payload);
    end
    out_ready = 1;
    step();
    out_ready = 0;
  endtask
  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_payload = 16'(16'h30 + i);
      step();
    end
    in_valid = 0;
    #2 rst = 1;
    #1;
    checks++;
    if ({out_valid, in_ready, level, in_pkt_cnt, flush_drop_cnt, high_water} !== 42'd0) begin
      failures++;
      $display("FAIL rst_mid got v=%b rdy=%b lvl=%0d in=%0d drop=%0d hw=%0d exp all 0", out_valid, in_ready, level, in_pkt_cnt, flush_drop_cnt, high_water);
    end
    #1 rst = 0;
    in_valid = 1; in_payload = 16'h0077;
    step();
    in_valid = 0;
    checks++;
    if ({level, out_valid, out_payload, in_pkt_cnt} !== {4'd1, 1'b1, 16'h0077, 16'd1}) begin
      failures++;
      $display("FAIL rst_resume got lvl=%0d v=%b pl=%h in=%0d exp 1/1/0077/1", level, out_valid, out_payload, in_pkt_cnt);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_stream();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpm_ingress_fifo.md
Name: cpm_ingress_fifo

Overview:
- Elastic buffer directly upstream of the CPM core input stream port.
- Accepts packets (id/opcode/payload) from the external source and presents them to the core under the same valid/ready protocol.
- Absorbs core backpressure and keeps the core-facing stream protocol-clean: no valid drop and no field change while stalled.
- Exports occupancy and traffic statistics for the register block.

Parameters:
- DEPTH, 8, number of entries; power of 2, >= 2.
- AFULL_THRESH, 6, almost_full asserts when level >= this value; range 1..DEPTH.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  upstream packet valid.
- in_ready  out  1  FIFO can accept a packet this cycle.
- in_id  in  4  packet id.
- in_opcode  in  4  packet opcode.
- in_payload  in  16  packet payload.
- out_valid  out  1  head entry valid toward the CPM core.
- out_ready  in  1  CPM core accepts the head entry.
- out_id  out  4  head id.
- out_opcode  out  4  head opcode.
- out_payload  out  16  head payload.
- flush  in  1  synchronous discard of buffered packets.
- clr_stats  in  1  synchronous clear of counters and high_water.
- level  out  $clog2(DEPTH)+1  current entry count.
- almost_full  out  1  level >= AFULL_THRESH.
- high_water  out  $clog2(DEPTH)+1  maximum level since reset or clr_stats.
- in_pkt_cnt  out  CNT_W  accepted input packets; wraps.
- out_pkt_cnt  out  CNT_W  delivered output packets; wraps.
- flush_drop_cnt  out  CNT_W  packets discarded by flush; saturates at all-ones.

Behaviour:
- Reset (async, rst=1): pointers, level, high_water and all counters = 0; out_valid=0; almost_full=0. in_ready = 1 after reset deasserts; it is 0 while rst=1. Storage contents are don't-care.
- Handshakes:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (level != DEPTH) && !flush && !rst. It is combinational only on flush; otherwise it is derived from flops.
- Output path: first-word fall-through. out_valid = (level != 0). out_* = storage[rd_ptr], driven from flops with no combinational path from in_*.
- Latency: a packet pushed at edge N into an empty FIFO appears on out_* with out_valid=1 after edge N, i.e. one cycle.
- Stability:
  - While out_valid && !out_ready, out_valid and out_* hold.
  - rd_ptr advances only on pop.
  - A write never targets an occupied slot.
- Full: in_ready=0 at level==DEPTH. A pop in that cycle frees the slot for the next cycle only; there is no same-cycle push-through when full.
- Empty: out_valid=0. A push into an empty FIFO is not bypassed to the output in the same cycle.
- Simultaneous push and pop: level unchanged; both pointers advance.
- Pointer arithmetic: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level is tracked explicitly. Next level = level + push - pop.
- Flush (priority over push; cycle with flush=1):
  - No push occurs.
  - If a pop occurs: all remaining entries are discarded; level -> 0; flush_drop_cnt += level-1.
  - Else if out_valid: the stalled head is retained (protects the stability rule); others are discarded; level -> 1; flush_drop_cnt += level-1.
  - Else: level stays 0; no drops.
  - Pointers are rebased so that rd_ptr is preserved.
- Stats:
  - in_pkt_cnt increments per push; out_pkt_cnt per pop.
  - flush_drop_cnt adds saturating.
  - high_water updates to next-level when next-level > high_water.
  - clr_stats: all counters -> 0 and high_water -> next-level. Events in the same cycle are not counted.
- almost_full is registered and computed from next-level, so it is consistent with level every cycle.
- Reset mid-operation: immediate async clear. Buffered packets are lost and are not counted as drops.

Test Plan:
- Single packet: push id=3, opcode=5, payload=0xBEEF into empty FIFO with out_ready=1 -> out_valid high the next cycle with the same fields; popped; level back to 0; in_pkt_cnt=out_pkt_cnt=1.
- Fill/stall: out_ready=0, push 8 packets (payload 0..7) -> in_ready=0 at level 8; almost_full=1 from level 6; out_* held at payload 0 for 20 cycles; high_water=8.
- Full plus pop: at level 8, out_ready=1 for one cycle with in_valid=1 -> no push that cycle; next cycle in_ready=1; push accepted; order preserved (1..7 then new packet).
- Streaming: in_valid=out_ready=1 for 100 cycles with incrementing payload -> level stays 1; output is in-order, no gaps after the first packet; both counters = 100.
- Flush stalled: level 5, out_ready=0, flush=1 -> level 1; head unchanged; flush_drop_cnt=4. Same with out_ready=1 -> level 0; flush_drop_cnt=8.
- Reset mid-traffic: assert rst asynchronously at level 4 -> out_valid, level and counters read 0 before the next clock edge; normal operation resumes after release.
